fixed_point_slow_axpy: RTL and testbench

Sequential fixed-point vector update P = alpha*X + Y, one element per cycle, sharing a single multiplier.
- It is the vector-producing counterpart of the team's serial dot-product unit: that unit reduces two vectors to a scalar; this one broadcasts a scalar back over a vector.
- Used for the step after a projection, e.g. subtracting a projected component or scaling a direction vector.
- Ready/valid handshake on both sides, so it can sit between pipeline stages that stall.

---
 rtl/fixed_point_slow_axpy.sv | 177 +++++++++++++++++
 tb/tb_fixed_point_slow_axpy.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_slow_axpy.sv
// fixed_point_slow_axpy
//   Serial fixed-point vector update P = alpha*X + Y, one element per clock,
//   sharing a single multiplier. The operands are latched on accept, so the
//   input ports are free to change while the vector is being computed.
//
// Optional build macro:
//   FIXED_POINT_SLOW_AXPY_SAT_EN  defined   -> saturate the product and the sum
//                                 undefined -> two's-complement wrap of the sum
//
// Ports:
//   clk_in     clock
//   rst_in     synchronous active-high reset
//   alpha      signed scalar, A_WIDTH bits, A_FRAC_BITS fractional
//   X          N signed elements, B_WIDTH bits, B_FRAC_BITS fractional
//   Y          N signed elements, P_WIDTH bits, P_FRAC_BITS fractional
//   valid_in   operands valid
//   ready_out  block can accept operands (IDLE)
//   P          N signed result elements, P_WIDTH bits
//   valid_out  P complete and valid (DONE)
//   ready_in   downstream accepts P
//
// States:
//   S_IDLE | waiting for operands, ready_out=1
//   S_RUN  | computing element idx_q, one per clock
//   S_DONE | result held, valid_out=1 until ready_in
module fixed_point_slow_axpy #(
  parameter  int A_WIDTH         = 16,
  parameter  int A_FRAC_BITS     = 14,
  parameter  int B_WIDTH         = 16,
  parameter  int B_FRAC_BITS     = 14,
  parameter  int P_FRAC_BITS     = 14,
  parameter  int N               = 3,
  localparam int EXTRA_FRAC_BITS = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS,
  localparam int P_WIDTH         = A_WIDTH + B_WIDTH - EXTRA_FRAC_BITS
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic signed [A_WIDTH-1:0]        alpha,
  input  logic signed [N-1:0][B_WIDTH-1:0] X,
  input  logic signed [N-1:0][P_WIDTH-1:0] Y,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic signed [N-1:0][P_WIDTH-1:0] P,
  output logic                             valid_out,
  input  logic                             ready_in
);

  localparam int PROD_W = A_WIDTH + B_WIDTH;
  localparam int IDX_W  = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       load;
  logic                       wr_en;

  logic [A_WIDTH-1:0]         alpha_q;
  logic [N-1:0][B_WIDTH-1:0]  x_q;
  logic [N-1:0][P_WIDTH-1:0]  y_q;
  logic [N-1:0][P_WIDTH-1:0]  p_q;

  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   prod_sh;
  logic [P_WIDTH-1:0]         prod_p;
  logic [P_WIDTH-1:0]         y_el;
  logic [P_WIDTH-1:0]         elem_res;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wr_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ready_in) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = (state_q == S_DONE);

  // ---------------- datapath ----------------
  always_comb begin
    prod    = $signed(alpha_q) * $signed(x_q[idx_q]);
    // Arithmetic shift: floor rounding toward -inf.
    prod_sh = prod >>> EXTRA_FRAC_BITS;
    y_el    = y_q[idx_q];
  end

`ifdef FIXED_POINT_SLOW_AXPY_SAT_EN
  localparam logic signed [PROD_W-1:0] PROD_MAX =
    {{(PROD_W - P_WIDTH + 1){1'b0}}, {(P_WIDTH - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] PROD_MIN =
    {{(PROD_W - P_WIDTH + 1){1'b1}}, {(P_WIDTH - 1){1'b0}}};

  logic [P_WIDTH:0] sum;

  always_comb begin
    if (prod_sh > PROD_MAX)      prod_p = {1'b0, {(P_WIDTH - 1){1'b1}}};
    else if (prod_sh < PROD_MIN) prod_p = {1'b1, {(P_WIDTH - 1){1'b0}}};
    else                         prod_p = prod_sh[P_WIDTH-1:0];

    sum = {prod_p[P_WIDTH-1], prod_p} + {y_el[P_WIDTH-1], y_el};

    // Overflow when the guard bit disagrees with the result sign bit.
    if (sum[P_WIDTH] != sum[P_WIDTH-1])
      elem_res = sum[P_WIDTH] ? {1'b1, {(P_WIDTH - 1){1'b0}}}
                              : {1'b0, {(P_WIDTH - 1){1'b1}}};
    else
      elem_res = sum[P_WIDTH-1:0];
  end
`else
  // The guard bit of the widened sum is discarded by the wrap, so the add
  // is done directly at P_WIDTH.
  always_comb begin
    prod_p   = prod_sh[P_WIDTH-1:0];
    elem_res = prod_p + y_el;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alpha_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
    end else begin
      if (load) begin
        alpha_q <= alpha;
        x_q     <= X;
        y_q     <= Y;
      end
      if (wr_en) p_q[idx_q] <= elem_res;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_fixed_point_slow_axpy.sv
module tb_fixed_point_slow_axpy;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int PW = 18;

  logic                        clk_in = 1'b0;
  logic                        rst_in;
  logic signed [AW-1:0]        alpha;
  logic signed [N-1:0][BW-1:0] X;
  logic signed [N-1:0][PW-1:0] Y;
  logic                        valid_in;
  logic                        ready_out;
  logic signed [N-1:0][PW-1:0] P;
  logic                        valid_out;
  logic                        ready_in;

  int n_checks = 0;
  int n_pass   = 0;

  fixed_point_slow_axpy dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .alpha     (alpha),
    .X         (X),
    .Y         (Y),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .P         (P),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_ops(input longint a, input longint x0, input longint x1,
                         input longint x2, input longint y0, input longint y1,
                         input longint y2);
    alpha = AW'(a);
    X[0]  = BW'(x0);
    X[1]  = BW'(x1);
    X[2]  = BW'(x2);
    Y[0]  = PW'(y0);
    Y[1]  = PW'(y1);
    Y[2]  = PW'(y2);
  endtask

  task automatic check_p(input string tag, input longint e0, input longint e1,
                         input longint e2);
    check({tag, "_p0"}, longint'($signed(P[0])), e0);
    check({tag, "_p1"}, longint'($signed(P[1])), e1);
    check({tag, "_p2"}, longint'($signed(P[2])), e2);
  endtask

  // Issue one op from IDLE and wait for valid_out; optionally scramble the
  // inputs (and pulse valid_in) every cycle while the op is running.
  task automatic issue(input string tag, input bit scramble);
    int cnt;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    check({tag, "_busy"}, longint'(ready_out), 0);
    cnt = 0;
    while (!valid_out && cnt < 20) begin
      if (scramble) begin
        alpha    = AW'($urandom());
        X        = (N*BW)'({$urandom(), $urandom()});
        Y        = (N*PW)'({$urandom(), $urandom()});
        valid_in = 1'b1;
      end
      @(posedge clk_in); #1;
      cnt++;
    end
    valid_in = 1'b0;
    check({tag, "_latency"}, longint'(cnt), N);
  endtask

  task automatic release_result(input string tag);
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    check({tag, "_vo_drop"}, longint'(valid_out), 0);
    check({tag, "_ro_back"}, longint'(ready_out), 1);
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", longint'(ready_out), 1);
    check("rst_valid", longint'(valid_out), 0);
    check_p("rst", 0, 0, 0);
    rst_in = 1'b0;

    // basic update: 0.5 * {1,-1,0.5} + {0,1,0}
    set_ops(8192, 16384, -16384, 8192, 0, 16384, 0);
    issue("basic", 1'b0);
    check_p("basic", 8192, 8192, 4096);
    release_result("basic");

    // floor rounding
    set_ops(8192, 1, 1, 1, 0, 0, 0);
    issue("floor_pos", 1'b0);
    check_p("floor_pos", 0, 0, 0);
    release_result("floor_pos");

    set_ops(-8192, 1, 1, 1, 0, 0, 0);
    issue("floor_neg", 1'b0);
    check_p("floor_neg", -1, -1, -1);
    release_result("floor_neg");

    set_ops(-16384, 1, 2, 3, 0, 0, 0);
    issue("neg_one", 1'b0);
    check_p("neg_one", -1, -2, -3);
    release_result("neg_one");

    // overflow: 65532 + 131071 = 196603 does not fit in 18 signed bits
    set_ops(32767, 32767, 0, 0, 131071, 0, 0);
    issue("ovf", 1'b0);
`ifdef FIXED_POINT_SLOW_AXPY_SAT_EN
    check_p("ovf", 131071, 0, 0);
`else
    check_p("ovf", -65541, 0, 0);
`endif
    release_result("ovf");

    // backpressure with a new op offered during the hold
    set_ops(8192, 16384, -16384, 8192, 0, 16384, 0);
    issue("bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        set_ops(-16384, 100, 200, 300, 7, 7, 7);
        valid_in = 1'b1;
      end
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      check("bp_valid", longint'(valid_out), 1);
      check("bp_ready", longint'(ready_out), 0);
      check_p("bp_hold", 8192, 8192, 4096);
    end
    release_result("bp");

    // input isolation: -1*{1,2,3} + {10,20,30}
    set_ops(-16384, 1, 2, 3, 10, 20, 30);
    issue("iso", 1'b1);
    check_p("iso", 9, 18, 27);
    release_result("iso");

    // reset during the second RUN cycle
    set_ops(8192, 16384, -16384, 8192, 0, 16384, 0);
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("midrst_valid", longint'(valid_out), 0);
    check("midrst_ready", longint'(ready_out), 1);
    check_p("midrst", 0, 0, 0);

    set_ops(-16384, 5, -6, 7, 100, 100, 100);
    issue("after_rst", 1'b0);
    check_p("after_rst", 95, 106, 93);
    release_result("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
